output_argmax_classifier: RTL

//  Final DNN stage. Consumes the two signed scores of the output layer (neurons N8/N9) and their ready strobes.

---
 rtl/output_argmax_classifier.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/output_argmax_classifier.sv
// output_argmax_classifier: final DNN stage. Pairs the two output-layer scores,
// registers the winning class and |score0-score1|, and holds the result until
// the consumer acknowledges it. Also keeps a wrapping result count and a sticky
// flag for strobes that arrived while no capture was possible.
//
// Handshake: class_valid rises with a new result and stays high, with class_out
// and margin stable, until a rising edge samples class_ack=1; that edge clears
// class_valid. class_ack is ignored while class_valid=0. Strobes sampled on the
// acknowledging edge are captured as if the block were idle.
module output_argmax_classifier #(
  parameter int output_width = 17,
  parameter int CNT_W        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [output_width-1:0] in0,
  input  logic signed [output_width-1:0] in1,
  input  logic                           in0_ready,
  input  logic                           in1_ready,
  input  logic                           class_ack,
  output logic                           class_out,
  output logic        [output_width:0]   margin,
  output logic                           class_valid,
  output logic        [CNT_W-1:0]        class_count,
  output logic                           drop_err,
  output logic        [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PARTIAL = 2'd1,
    S_CALC    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [output_width-1:0]   r_cap0;
  logic [output_width-1:0]   r_cap1;
  logic                      r_got0;
  logic                      r_got1;
  logic                      r_class;
  logic [output_width:0]     r_margin;
  logic                      r_valid;
  logic [CNT_W-1:0]          r_count;
  logic                      r_drop;

  logic                      w_cap_en;
  logic                      w_drop;
  logic                      w_g0;
  logic                      w_g1;
  logic [output_width:0]     w_diff;
  logic                      w_neg;
  logic [output_width:0]     w_abs;

  // Difference computed one bit wider than the scores so it can never overflow.
  always_comb begin
    w_diff = {r_cap0[output_width-1], r_cap0} - {r_cap1[output_width-1], r_cap1};
    w_neg  = w_diff[output_width];
    w_abs  = w_neg ? (~w_diff + {{output_width{1'b0}}, 1'b1}) : w_diff;
  end

  // Next-state, capture-enable and drop detection.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_en    = 1'b0;
    w_drop      = 1'b0;
    w_g0        = r_got0 | in0_ready;
    w_g1        = r_got1 | in1_ready;
    case (r_state)
      S_IDLE, S_PARTIAL: w_cap_en = 1'b1;
      S_CALC: begin
        w_drop      = in0_ready | in1_ready;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (class_ack) w_cap_en = 1'b1;
        else           w_drop   = in0_ready | in1_ready;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_cap_en) begin
      if (w_g0 && w_g1)      w_state_nxt = S_CALC;
      else if (w_g0 || w_g1) w_state_nxt = S_PARTIAL;
      else                   w_state_nxt = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Score capture and got flags; flags clear once the pair is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap0 <= '0;
      r_cap1 <= '0;
      r_got0 <= 1'b0;
      r_got1 <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_got0 <= 1'b0;
      r_got1 <= 1'b0;
    end else if (w_cap_en) begin
      if (in0_ready) begin
        r_cap0 <= in0;
        r_got0 <= 1'b1;
      end
      if (in1_ready) begin
        r_cap1 <= in1;
        r_got1 <= 1'b1;
      end
    end
  end

  // Result registers, valid flag and wrapping count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class  <= 1'b0;
      r_margin <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else if (r_state == S_CALC) begin
      r_class  <= w_neg;
      r_margin <= w_abs;
      r_valid  <= 1'b1;
      r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (r_state == S_HOLD && class_ack) begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_drop <= 1'b0;
    else if (w_drop) r_drop <= 1'b1;
  end

  assign class_out   = r_class;
  assign margin      = r_margin;
  assign class_valid = r_valid;
  assign class_count = r_count;
  assign drop_err    = r_drop;
  assign dbg_state   = r_state;

endmodule
